// File: rtl/multicycle_right_shifter_pkg.sv
// Shared types for the multicycle right shifter: FSM state encoding.
package multicycle_right_shifter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/multicycle_right_shifter_step.sv
// Fixed-distance combinational right shift by S bits, logical or arithmetic.
module right_shift_step
   import multicycle_right_shifter_pkg::*;
#(
   parameter int N = 8,
   parameter int S = 1
) (
   input  logic [N-1:0] a,
   input  logic         arith,
   output logic [N-1:0] res
);

   logic fill_s;

   assign fill_s = arith & a[N-1];
   assign res    = {{S{fill_s}}, a[N-1:S]};

endmodule

// File: rtl/multicycle_right_shifter.sv
// Iterative right shifter: coarse STEP-bit steps while the remaining amount allows,
// then single-bit steps; operand and result move over valid/ready handshakes.
module multicycle_right_shifter
   import multicycle_right_shifter_pkg::*;
#(
   parameter int  N    = 8,
   parameter int  STEP = 4,
   localparam int SW   = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_data,
   input  logic [SW-1:0] up_shamt,
   input  logic          up_arith,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_data
);

   localparam logic [SW-1:0] STEP_C = SW'(STEP);
   localparam logic [SW-1:0] ONE_C  = SW'(1);

   state_t        state_r, state_s;
   logic [N-1:0]  data_r, data_s;
   logic [SW-1:0] rem_r, rem_s;
   logic          arith_r, arith_s;
   logic [N-1:0]  coarse_s, fine_s;
   logic          use_coarse_s;

   right_shift_step #(.N(N), .S(STEP)) u_step_coarse (
      .a     (data_r),
      .arith (arith_r),
      .res   (coarse_s)
   );

   right_shift_step #(.N(N), .S(1)) u_step_fine (
      .a     (data_r),
      .arith (arith_r),
      .res   (fine_s)
   );

   assign use_coarse_s = (rem_r >= STEP_C);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         data_r  <= '0;
         rem_r   <= '0;
         arith_r <= 1'b0;
      end else begin
         state_r <= state_s;
         data_r  <= data_s;
         rem_r   <= rem_s;
         arith_r <= arith_s;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_s = state_r;
      data_s  = data_r;
      rem_s   = rem_r;
      arith_s = arith_r;
      case (state_r)
         IDLE: begin
            if (up_valid) begin
               data_s  = up_data;
               rem_s   = up_shamt;
               arith_s = up_arith;
               if (up_shamt == '0) begin
                  state_s = DONE;
               end else begin
                  state_s = SHIFT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (use_coarse_s) begin
               data_s = coarse_s;
               rem_s  = rem_r - STEP_C;
            end else begin
               data_s = fine_s;
               rem_s  = rem_r - ONE_C;
            end
            // rem_r is nonzero in SHIFT, so neither subtraction can wrap.
            if (rem_s == '0) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (down_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign up_ready   = (state_r == IDLE) & ~rst;
   assign down_valid = (state_r == DONE);
   assign down_data  = data_r;

endmodule

// File: tb/tb_multicycle_right_shifter.sv
// Scoreboard bench for multicycle_right_shifter: directed cases, DONE stall,
// mid-operation reset and a full operand/amount/mode sweep with random stalls.
module tb_multicycle_right_shifter;

   localparam int N    = 8;
   localparam int STEP = 4;
   localparam int SW   = $clog2(N);

   typedef struct {
      logic [7:0] e_data;
      int         e_lat;
      int         acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          up_valid = 1'b0;
   logic          up_ready;
   logic [N-1:0]  up_data = '0;
   logic [SW-1:0] up_shamt = '0;
   logic          up_arith = 1'b0;
   logic          down_valid;
   logic          down_ready = 1'b1;
   logic [N-1:0]  down_data;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   bit   dv_seen = 1'b0;

   multicycle_right_shifter #(.N(N), .STEP(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_shamt   (up_shamt),
      .up_arith   (up_arith),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s, input logic a);
      logic signed [7:0] sd;
      sd = d;
      if (a) return 8'(sd >>> s);
      return d >> s;
   endfunction

   function automatic int ref_lat(input logic [2:0] s);
      return int'(s) / STEP + int'(s) % STEP + 1;
   endfunction

   // Consumer: always ready, randomly stalling, or held off.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       down_ready = 1'b1;
            1:       down_ready = ($urandom_range(3) != 0);
            default: down_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compare results and first-valid latency against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         dv_seen = 1'b0;
      end else if (down_valid) begin
         if (sb.size() == 0) begin
            check_eq("spurious_down_valid", 32'(down_valid), 32'd0);
         end else begin
            if (!dv_seen) begin
               dv_seen = 1'b1;
               check_eq("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].e_lat));
            end
            check_eq("down_data", 32'(down_data), 32'(sb[0].e_data));
            if (down_ready) begin
               void'(sb.pop_front());
               dv_seen = 1'b0;
            end
         end
      end
   end

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (sb.size() != 0) begin
         check_eq("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic req(input logic [7:0] d, input logic [2:0] s, input logic a,
                      input logic [7:0] want, input bit wait_done);
      int n = 0;
      @(posedge clk);
      #2;
      up_valid = 1'b1;
      up_data  = d;
      up_shamt = s;
      up_arith = a;
      forever begin
         @(negedge clk);
         if (up_ready || n > 50) break;
         n++;
      end
      if (up_ready) begin
         sb.push_back('{e_data: want, e_lat: ref_lat(s), acc: cyc + 1});
      end else begin
         check_eq("accept_timeout", 32'(up_ready), 32'd1);
      end
      @(posedge clk);
      #2;
      up_valid = 1'b0;
      up_data  = 8'($urandom);
      up_shamt = 3'($urandom);
      up_arith = 1'($urandom);
      if (wait_done) wait_empty();
   endtask

   initial begin
      int n;

      // Reset state.
      repeat (2) @(negedge clk);
      check_eq("rst_up_ready", 32'(up_ready), 32'd0);
      check_eq("rst_down_valid", 32'(down_valid), 32'd0);
      check_eq("rst_down_data", 32'(down_data), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_up_ready", 32'(up_ready), 32'd1);
      check_eq("post_rst_down_valid", 32'(down_valid), 32'd0);

      // Directed cases with constant expectations.
      req(8'hB4, 3'd7, 1'b0, 8'h01, 1'b1);
      req(8'hB4, 3'd7, 1'b1, 8'hFF, 1'b1);
      req(8'hB4, 3'd2, 1'b1, 8'hED, 1'b1);
      req(8'h5A, 3'd0, 1'b0, 8'h5A, 1'b1);
      req(8'h5A, 3'd4, 1'b0, 8'h05, 1'b1);
      req(8'h80, 3'd5, 1'b1, 8'hFC, 1'b1);

      // Stall in DONE while up_valid/up_data toggle.
      rdy_mode = 2;
      req(8'hB4, 3'd2, 1'b0, 8'h2D, 1'b0);
      n = 0;
      while (!down_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("hold_reached_done", 32'(down_valid), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #2;
         up_valid = ~up_valid;
         up_data  = 8'($urandom);
         @(negedge clk);
         check_eq("hold_up_ready", 32'(up_ready), 32'd0);
         check_eq("hold_down_valid", 32'(down_valid), 32'd1);
         check_eq("hold_no_capture", 32'(sb.size()), 32'd1);
      end
      @(posedge clk);
      #2;
      up_valid = 1'b0;
      rdy_mode = 0;
      wait_empty();
      @(negedge clk);
      check_eq("hold_release_idle", 32'(up_ready), 32'd1);
      req(8'h3C, 3'd3, 1'b0, 8'h07, 1'b1);

      // Reset during SHIFT discards the in-flight request.
      req(8'hB4, 3'd7, 1'b0, 8'h01, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_up_ready", 32'(up_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check_eq("midrst_no_down_valid", 32'(down_valid), 32'd0);
         @(negedge clk);
      end
      req(8'hC3, 3'd6, 1'b1, 8'hFF, 1'b1);
      req(8'hC3, 3'd1, 1'b0, 8'h61, 1'b1);

      // Full sweep against the reference with random consumer stalls.
      rdy_mode = 1;
      for (int d = 0; d < 256; d++) begin
         for (int s = 0; s < N; s++) begin
            for (int a = 0; a < 2; a++) begin
               req(8'(d), 3'(s), 1'(a), ref_shift(8'(d), 3'(s), 1'(a)), 1'b1);
            end
         end
      end

      rdy_mode = 0;
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_right_shifter.md
# multicycle_right_shifter

Sequential variable-amount right shifter for N-bit operands. It accepts an operand and a shift amount over a valid/ready handshake, then iterates fixed-distance shift steps: STEP bits per cycle while possible, then 1 bit per cycle. It presents the result over a second valid/ready handshake. It sits directly downstream of the fixed combinational shift stages and reuses them as its per-cycle datapath. It trades latency for area against a full barrel shifter.

## Interface
- N, 8, operand width; N ≥ 2
- STEP, 4, coarse shift distance per cycle; 1 ≤ STEP ≤ N-1
- SW, $clog2(N), shift-amount width (derived, not overridden)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high (fixed)
- up_valid  input  1  operand/amount valid
- up_ready  output  1  block can accept a request
- up_data  input  N  unsigned/signed operand
- up_shamt  input  SW  shift amount, 0..N-1
- up_arith  input  1  1 = arithmetic shift (replicate MSB), 0 = logical shift (fill with zeros)
- down_valid  output  1  result valid
- down_ready  input  1  consumer accepts result
- down_data  output  N  shifted result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - up_ready=1.
  - On up_valid, capture up_data into data_r, up_shamt into rem_r, up_arith into arith_r.
  - Next state is DONE if up_shamt==0, else SHIFT.
- SHIFT:
  - up_ready=0, down_valid=0.
  - Each cycle: if rem_r ≥ STEP, then data_r ← data_r shifted right by STEP and rem_r ← rem_r−STEP.
  - Otherwise data_r ← data_r shifted right by 1 and rem_r ← rem_r−1.
  - Fill bits are 0 when arith_r=0, and data_r[N-1] as sampled before the step when arith_r=1.
  - When the updated rem_r equals 0, go to DONE.
- DONE:
  - down_valid=1, down_data=data_r.
  - On down_ready, go to IDLE.
  - down_data stays stable while down_valid=1 and down_ready=0.
- No new request is accepted in SHIFT or DONE. up_ready and up_valid are ignored outside IDLE.
- Arithmetic rules:
  - The result equals up_data >> up_shamt (logical) or $signed(up_data) >>> up_shamt (arithmetic).
  - rem_r is SW bits wide and never underflows.
- up_data, up_shamt and up_arith are sampled only on the accepting edge. Later changes have no effect.

## Timing
- Reset, while rst=1 and on the cycle following deassertion-edge sampling:
  - state=IDLE, rem_r=0, data_r=0, arith_r=0.
  - up_ready=0 while rst=1; down_valid=0; down_data=0.
- Reset mid-operation, in SHIFT or DONE: the in-flight result is discarded with no down_valid pulse. up_ready=1 on the first cycle after rst falls.
- Shift cycles: k = floor(s/STEP) + (s mod STEP) for s=up_shamt.
- Latency: acceptance edge, then k SHIFT edges, then down_valid=1 in the next cycle.
  - s=0: down_valid is high in the cycle immediately after acceptance.
- Throughput: one result per k+2 cycles minimum, including the DONE→IDLE handshake cycle.
- If down_ready=1 is already high when DONE is entered, the transfer completes on that first DONE edge and up_ready=1 in the following cycle.
- up_ready and down_valid are pure decodes of the state register, with up_ready also gated by rst. There is no combinational path from up_valid or down_ready to them.

## Structure
- Shared package multicycle_right_shifter_pkg: enum state_t {IDLE, SHIFT, DONE}.
- Sub-module right_shift_step:
  - Combinational, parameters N and S; inputs a[N-1:0] and arith; output res[N-1:0].
  - Fill pattern: S copies of (arith & a[N-1]) concatenated with a[N-1:S].
  - Instantiate twice: S=STEP and S=1.
  - The FSM muxes between the two instances on rem_r ≥ STEP.

## Test plan
- N=8, STEP=4, up_data=0xB4, shamt=7, arith=0 -> 4 SHIFT cycles; down_valid 5 cycles after accept; down_data=0x01.
- Same operand, shamt=7, arith=1 -> down_data=0xFF; shamt=2, arith=1 -> down_data=0xED after 2 SHIFT cycles.
- shamt=0, up_data=0x5A -> down_valid in the next cycle, down_data=0x5A; shamt=4 -> 1 SHIFT cycle, result 0x05.
- Hold down_ready=0 for 6 cycles in DONE while toggling up_valid and up_data -> down_data stays constant, up_ready=0, no second capture; release -> IDLE, next request accepted.
- Assert rst for 1 cycle during SHIFT (shamt=7) -> down_valid never pulses for that request; up_ready=1 after reset; a fresh request completes correctly.
- Random sweep of all 256 operands × all shamt × arith, with random down_ready stalls -> every result matches a >> / >>> reference; per-request latency equals k+1.
